// File: rtl/alu_overflow_flag.sv
// ---------------------------------------------------------------------------
// alu_overflow_flag
//   Produces the ARM-style V (signed overflow) flag for the ALU. It provides
//   a combinational overflow indication for the current operation, the
//   registered V flag in the status register, and a sticky overflow
//   indicator for debug and exception use.
//
// Ports
//   clk              system clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   src_a            ALU operand A (only the MSB is used)
//   src_b            ALU operand B, before the ALU's subtract inversion (MSB only)
//   alu_result       ALU result as produced by the ALU (MSB only)
//   alu_control      00 ADD, 01 SUB, 10 AND, 11 ORR
//   flag_w           V-flag write request from the decoder
//   cond_ex          condition passed; qualifies flag_w
//   sticky_clr       synchronous clear of overflow_sticky (wins over a set)
//   overflow         combinational overflow of the current operation
//   v_flag           registered V flag
//   overflow_sticky  set by any committed overflow, held until cleared
// ---------------------------------------------------------------------------
module alu_overflow_flag #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_control,
  input  logic             flag_w,
  input  logic             cond_ex,
  input  logic             sticky_clr,
  output logic             overflow,
  output logic             v_flag,
  output logic             overflow_sticky
);

  logic sa;
  logic sb;
  logic sr;
  logic wr_en;
  logic v_flag_d;
  logic v_flag_q;
  logic sticky_d;
  logic sticky_q;

  // Only the sign bits participate; the lower bits are left unused on purpose.
  assign sa = src_a[WIDTH-1];
  assign sb = src_b[WIDTH-1];
  assign sr = alu_result[WIDTH-1];

  // For SUB the ALU adds ~B, so the effective B sign is sb ^ alu_control[0].
  // Overflow occurs when the two effective operand signs agree and the
  // result sign differs from them. Logical ops never overflow.
  assign overflow = ~alu_control[1] & (sa ^ sr) & ~(alu_control[0] ^ sa ^ sb);

  assign wr_en = flag_w & cond_ex;

  always_comb begin
    v_flag_d = v_flag_q;
    sticky_d = sticky_q;
    if (wr_en) begin
      v_flag_d = overflow;
    end
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end else if (wr_en && overflow) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v_flag_q <= v_flag_d;
      sticky_q <= sticky_d;
    end
  end

  assign v_flag          = v_flag_q;
  assign overflow_sticky = sticky_q;

  // Lower operand bits are intentionally ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{src_a[WIDTH-2:0], src_b[WIDTH-2:0], alu_result[WIDTH-2:0]};

endmodule

// File: tb/tb_alu_overflow_flag.sv
module tb_alu_overflow_flag;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [W-1:0] alu_result;
  logic [1:0]   alu_control;
  logic         flag_w;
  logic         cond_ex;
  logic         sticky_clr;
  logic         overflow;
  logic         v_flag;
  logic         overflow_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  alu_overflow_flag #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_a           (src_a),
    .src_b           (src_b),
    .alu_result      (alu_result),
    .alu_control     (alu_control),
    .flag_w          (flag_w),
    .cond_ex         (cond_ex),
    .sticky_clr      (sticky_clr),
    .overflow        (overflow),
    .v_flag          (v_flag),
    .overflow_sticky (overflow_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic fw, input logic ce, input logic clr);
    alu_control = ctl;
    src_a       = a;
    src_b       = b;
    alu_result  = r;
    flag_w      = fw;
    cond_ex     = ce;
    sticky_clr  = clr;
  endtask

  task automatic check_regs(input string name, input logic exp_v, input logic exp_s);
    n_checks++;
    if (v_flag !== exp_v) begin
      n_fail++;
      $display("FAIL %s v_flag: got %b expected %b", name, v_flag, exp_v);
    end
    n_checks++;
    if (overflow_sticky !== exp_s) begin
      n_fail++;
      $display("FAIL %s overflow_sticky: got %b expected %b", name, overflow_sticky, exp_s);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp_o);
    n_checks++;
    if (overflow !== exp_o) begin
      n_fail++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow, exp_o);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(2'b00, 4'b1001, 4'b1010, 4'b0011, 1'b1, 1'b1, 1'b0);
    #1;
    check_regs("reset_initial", 1'b0, 1'b0);
    check_ovf("reset_ovf_comb", 1'b1);
    @(posedge clk);
    #1;
    check_regs("reset_held_over_edge", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b0011, 4'b0010, 4'b0101, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    @(negedge clk);
    drive(2'b00, 4'b1001, 4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("add_neg_neg", 1'b1);
    drive(2'b00, 4'b0111, 4'b0110, 4'b1101, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("add_pos_pos", 1'b1);
    drive(2'b00, 4'b0011, 4'b0010, 4'b0101, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("add_no_ovf", 1'b0);
    drive(2'b00, 4'b0111, 4'b1110, 4'b0101, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("add_mixed_signs", 1'b0);
    tick;
    check_regs("add_no_write", 1'b0, 1'b0);
  endtask

  task automatic test_sub;
    @(negedge clk);
    drive(2'b01, 4'b0111, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("sub_pos_minus_neg", 1'b1);
    drive(2'b01, 4'b1001, 4'b0010, 4'b0111, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("sub_neg_minus_pos", 1'b1);
    drive(2'b01, 4'b0111, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("sub_no_ovf", 1'b0);
    // Same-sign subtract can never overflow even with a flipped result sign.
    drive(2'b01, 4'b0111, 4'b0110, 4'b1001, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("sub_same_sign", 1'b0);
  endtask

  task automatic test_logic;
    @(negedge clk);
    drive(2'b10, 4'b0111, 4'b0110, 4'b1101, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("and_no_ovf", 1'b0);
    drive(2'b11, 4'b0111, 4'b0110, 4'b1101, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("orr_no_ovf", 1'b0);
    drive(2'b11, 4'b1001, 4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0); #1;
    check_ovf("orr_neg_neg", 1'b0);
  endtask

  task automatic test_write_qualify;
    @(negedge clk);
    drive(2'b00, 4'b1001, 4'b1010, 4'b0011, 1'b1, 1'b0, 1'b0);
    tick;
    check_regs("cond_fail_no_write", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b1001, 4'b1010, 4'b0011, 1'b0, 1'b1, 1'b0);
    tick;
    check_regs("flag_w_low_no_write", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b1001, 4'b1010, 4'b0011, 1'b1, 1'b1, 1'b0);
    #1;
    check_regs("write_before_edge", 1'b0, 1'b0);
    tick;
    check_regs("ovf_write_sets", 1'b1, 1'b1);
    @(negedge clk);
    drive(2'b00, 4'b0011, 4'b0010, 4'b0101, 1'b1, 1'b1, 1'b0);
    tick;
    check_regs("nonovf_write_clears_v", 1'b0, 1'b1);
    @(negedge clk);
    drive(2'b01, 4'b0111, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b0);
    tick;
    check_regs("hold_no_write", 1'b0, 1'b1);
  endtask

  task automatic test_sticky_clr;
    @(negedge clk);
    drive(2'b01, 4'b0111, 4'b1110, 4'b1001, 1'b1, 1'b1, 1'b1);
    tick;
    check_regs("clr_beats_set", 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b10, 4'b0111, 4'b0110, 4'b1101, 1'b1, 1'b1, 1'b0);
    tick;
    check_regs("logic_write_zeroes_v", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b0111, 4'b0110, 4'b1101, 1'b1, 1'b1, 1'b0);
    tick;
    check_regs("resets_up", 1'b1, 1'b1);
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2;
    drive(2'b00, 4'b0111, 4'b0110, 4'b1101, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_regs("async_reset_immediate", 1'b0, 1'b0);
    check_ovf("ovf_during_reset", 1'b1);
    tick;
    check_regs("pending_write_discarded", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b0111, 4'b0110, 4'b1101, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick;
    check_regs("after_release_no_write", 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 4'b0111, 4'b0110, 4'b1101, 1'b1, 1'b1, 1'b0);
    tick;
    check_regs("after_release_write", 1'b1, 1'b1);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_write_qualify;
    test_sticky_clr;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_overflow_flag.md
Name: alu_overflow_flag

Overview:
- Computes the ARM-style V (signed overflow) flag for the ALU and holds it in the status register.
- Takes the ALU operands, the ALU result and the 2-bit ALU control code.
- Produces two outputs:
  - a combinational overflow indication for the current operation;
  - a registered V flag, written only when the flag write is enabled and the condition passes.
- Also keeps a sticky overflow indicator for debug/exception use.
- Sits beside the ALU, feeding the condition-check logic of the ARM datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; only bit WIDTH-1 (the sign bit) is used; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- src_a  input  WIDTH  ALU operand A.
- src_b  input  WIDTH  ALU operand B, before the ALU's internal inversion for subtract.
- alu_result  input  WIDTH  ALU result for src_a op src_b.
- alu_control  input  2  operation code:
  - 00 = ADD;
  - 01 = SUB (A-B);
  - 10 = AND;
  - 11 = ORR.
- flag_w  input  1  V-flag write request from the decoder (S bit set).
- cond_ex  input  1  instruction condition passed; the write is qualified by it.
- sticky_clr  input  1  synchronous clear of overflow_sticky.
- overflow  output  1  combinational overflow of the current operation.
- v_flag  output  1  registered V flag.
- overflow_sticky  output  1  set by any committed overflow; held until cleared.

Behaviour:
- Sign bits: sa = src_a[WIDTH-1], sb = src_b[WIDTH-1], sr = alu_result[WIDTH-1].
- overflow is purely combinational, with no clock dependency: overflow = ~alu_control[1] & (sa ^ sr) & ~(alu_control[0] ^ sa ^ sb).
  - ADD (00): 1 iff sa == sb and sr != sa.
  - SUB (01): 1 iff sa != sb and sr != sa.
  - AND/ORR (1x): always 0.
- overflow is computed from alu_result exactly as presented; the block does not recompute the sum.
- Any X on a used input may propagate to overflow.
- wr_en = flag_w & cond_ex.
- v_flag:
  - on rising clk with wr_en = 1, v_flag <= overflow;
  - otherwise it holds its value;
  - one-cycle latency from operands to v_flag.
- A logical op with wr_en = 1 writes 0 into v_flag. ARM keeps V on logical ops; the decoder is responsible for deasserting flag_w for V in that case.
- overflow_sticky, on rising clk:
  - if sticky_clr = 1, it goes to 0; clear has priority over a simultaneous set;
  - else if wr_en & overflow, it goes to 1;
  - else it holds.
- Reset: rst_n = 0 immediately forces v_flag = 0 and overflow_sticky = 0, independent of clk.
  - Reset asserted mid-operation discards any pending write.
  - Registers resume on the first rising clk after rst_n deasserts.
  - overflow is unaffected by reset.
- Only the MSBs of the buses matter; the lower bits are ignored.

Test Plan (WIDTH=4):
- ADD, a=1001, b=1010, result=0011 -> overflow=1. With flag_w=cond_ex=1, v_flag=1 after the next edge.
- ADD, a=0111, b=0110, result=1101 -> overflow=1. ADD a=0011, b=0010, result=0101 -> overflow=0.
- SUB, a=0111, b=1110, result=1001 -> overflow=1. SUB a=1001, b=0010, result=0111 -> overflow=1. SUB a=0111, b=0110, result=0001 -> overflow=0.
- AND/ORR with a=0111, b=0110, result=1101 -> overflow=0 for alu_control 10 and 11.
- Overflowing ADD with flag_w=1 and cond_ex=0 -> v_flag and overflow_sticky unchanged. With cond_ex=1 -> both set. Then a non-overflow write -> v_flag=0 while overflow_sticky stays 1. sticky_clr asserted together with an overflow write -> overflow_sticky=0.
- Assert rst_n=0 between clock edges while v_flag=1 -> v_flag=0 and overflow_sticky=0 immediately. After release, no update occurs until a qualified write.
